// File: rtl/div_arbiter.sv
// div_arbiter
//   Shares one iterative divider among NREQ requesters. It picks a requester
//   round-robin and latches that requester's operands. It then pulses the
//   divider start, waits for finish, and returns a tagged response.
//   The latency does not depend on the operand values. A zero divisor is
//   still sent to the divider, so the result takes the same time as any other.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req                           per-requester request level
//   req_dividend/req_divisor      packed operands, slice i = requester i
//   gnt                           one-hot grant pulse (operands captured)
//   div_start                     divider start pulse
//   div_dividend/div_divisor      captured operands driven to the divider
//   div_quotient/div_remainder    divider results
//   div_finish                    divider done pulse
//   rsp_valid                     one-cycle response pulse
//   rsp_id                        requester index of the response
//   rsp_quotient/rsp_remainder    result (held until the next response)
//   rsp_dbz                       divisor was zero
//   rsp_err                       watchdog timeout, result forced to zero
//   busy                          high whenever the sequencer is not idle
module div_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int TMO   = 2 * WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       gnt,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder,
  input  logic                  div_finish,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_dbz,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic             start_reg, start_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic             dbz_reg, dbz_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0]   rsp_id_reg, rsp_id_next;
  logic [WIDTH-1:0] rsp_q_reg, rsp_q_next;
  logic [WIDTH-1:0] rsp_r_reg, rsp_r_next;
  logic             rsp_dbz_reg, rsp_dbz_next;
  logic             rsp_err_reg, rsp_err_next;
  logic             busy_reg, busy_next;

  // Unpack the per-requester operand slices.
  logic [WIDTH-1:0] dividend_arr [NREQ];
  logic [WIDTH-1:0] divisor_arr  [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign dividend_arr[gi] = req_dividend[gi*WIDTH +: WIDTH];
      assign divisor_arr[gi]  = req_divisor[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick. Rotate the request vector so that bit 0 is the
  // requester at ptr. The first set bit is then the offset of the winner
  // from ptr, and the index is reduced modulo NREQ.
  logic [2*NREQ-1:0] rot;
  logic              found;
  logic [IDW-1:0]    sel;
  logic [IDW:0]      sum;

  always_comb begin
    rot   = {req, req} >> ptr_reg;
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_reg} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        sel   = sum[IDW-1:0];
      end
    end
  end

  // Operand mux for the selected requester.
  logic [WIDTH-1:0] sel_dividend, sel_divisor;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel == IDW'(k)) begin
        sel_dividend = dividend_arr[k];
        sel_divisor  = divisor_arr[k];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    gnt_next       = '0;
    start_next     = 1'b0;
    dividend_next  = dividend_reg;
    divisor_next   = divisor_reg;
    id_next        = id_reg;
    dbz_next       = dbz_reg;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_q_next     = rsp_q_reg;
    rsp_r_next     = rsp_r_reg;
    rsp_dbz_next   = rsp_dbz_reg;
    rsp_err_next   = rsp_err_reg;

    unique case (state_reg)
      IDLE: begin
        if (found) begin
          for (int k = 0; k < NREQ; k++) gnt_next[k] = (sel == IDW'(k));
          start_next    = 1'b1;
          dividend_next = sel_dividend;
          divisor_next  = sel_divisor;
          id_next       = sel;
          dbz_next      = (sel_divisor == '0);
          ptr_next      = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        if (div_finish) begin
          rsp_valid_next = 1'b1;
          rsp_id_next    = id_reg;
          rsp_q_next     = div_quotient;
          rsp_r_next     = div_remainder;
          rsp_dbz_next   = dbz_reg;
          rsp_err_next   = 1'b0;
          state_next     = IDLE;
        end else if (cnt_reg == CW'(TMO-1)) begin
          // Watchdog expired: report an error with a zeroed result.
          rsp_valid_next = 1'b1;
          rsp_id_next    = id_reg;
          rsp_q_next     = '0;
          rsp_r_next     = '0;
          rsp_dbz_next   = dbz_reg;
          rsp_err_next   = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      start_reg     <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      id_reg        <= '0;
      dbz_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_q_reg     <= '0;
      rsp_r_reg     <= '0;
      rsp_dbz_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      start_reg     <= start_next;
      dividend_reg  <= dividend_next;
      divisor_reg   <= divisor_next;
      id_reg        <= id_next;
      dbz_reg       <= dbz_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_q_reg     <= rsp_q_next;
      rsp_r_reg     <= rsp_r_next;
      rsp_dbz_reg   <= rsp_dbz_next;
      rsp_err_reg   <= rsp_err_next;
      busy_reg      <= busy_next;
    end
  end

  assign gnt           = gnt_reg;
  assign div_start     = start_reg;
  assign div_dividend  = dividend_reg;
  assign div_divisor   = divisor_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_id        = rsp_id_reg;
  assign rsp_quotient  = rsp_q_reg;
  assign rsp_remainder = rsp_r_reg;
  assign rsp_dbz       = rsp_dbz_reg;
  assign rsp_err       = rsp_err_reg;
  assign busy          = busy_reg;

endmodule
